// File: rtl/fir_out_requant_if.sv
// Valid/ready output stream of the FIR requantizer: the requantizer drives
// samples as master, the downstream consumer accepts them as slave.
interface fir_out_requant_if #(
  parameter int WIDTH_OUT = 18
);
  logic                        m_valid;
  logic                        m_ready;
  logic signed [WIDTH_OUT-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fir_out_requant.sv
// Round-half-up, shift and saturate full-precision FIR results to WIDTH_OUT bits,
// then buffer them in a show-ahead FIFO with sticky saturation/overflow flags.
module fir_out_requant #(
  parameter int WIDTH_IN  = 54,
  parameter int WIDTH_OUT = 18,
  parameter int SHIFT     = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       din_valid,
  input  logic signed [WIDTH_IN-1:0] din,
  fir_out_requant_if.master          m,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  input  logic                       clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WIDTH_IN:0] ROUND = (WIDTH_IN+1)'(1) << (SHIFT - 1);
  localparam logic signed [WIDTH_IN:0] MAX_Q = (WIDTH_IN+1)'((1 << (WIDTH_OUT - 1)) - 1);
  localparam logic signed [WIDTH_IN:0] MIN_Q = ~MAX_Q;

  logic                        r_s1_valid;
  logic signed [WIDTH_IN:0]    r_s1_sum;
  logic                        r_s2_valid;
  logic signed [WIDTH_OUT-1:0] r_s2_data;

  logic signed [WIDTH_OUT-1:0] r_mem [DEPTH];
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [AW:0]                 r_count;
  logic signed [WIDTH_OUT-1:0] r_m_data;
  logic                        r_sat_flag;
  logic                        r_ovf_flag;

  logic signed [WIDTH_IN:0]    w_q;
  logic                        w_sat_hi;
  logic                        w_sat_lo;
  logic signed [WIDTH_OUT-1:0] w_q_sat;
  logic                        w_valid;
  logic                        w_full;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_wr;
  logic                        w_drop;
  logic [AW-1:0]               w_rd_next;

  // Stage 2 arithmetic: the extra sum bit keeps the rounding add from wrapping.
  assign w_q      = r_s1_sum >>> SHIFT;
  assign w_sat_hi = (w_q > MAX_Q);
  assign w_sat_lo = (w_q < MIN_Q);
  assign w_q_sat  = w_sat_hi ? MAX_Q[WIDTH_OUT-1:0] :
                    w_sat_lo ? MIN_Q[WIDTH_OUT-1:0] : w_q[WIDTH_OUT-1:0];

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_push    = ena && r_s2_valid;
  assign w_pop     = w_valid && m.m_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_rd_next = r_rd_ptr + AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (ena) begin
      r_s1_valid <= din_valid;
      r_s1_sum   <= {din[WIDTH_IN-1], din} + ROUND;
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_q_sat;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_s2_data;
  end

  // Head register: loaded with whichever entry becomes the head after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_m_data <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= w_rd_next;
      if (w_wr && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_pop) begin
        if (r_count != (AW+1)'(1)) r_m_data <= r_mem[w_rd_next];
        else if (w_wr)             r_m_data <= r_s2_data;
      end else if (w_wr && !w_valid) begin
        r_m_data <= r_s2_data;
      end
    end
  end

  // Clearing wins over a set arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_flags) begin
      r_sat_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else begin
      if (ena && r_s1_valid && (w_sat_hi || w_sat_lo)) r_sat_flag <= 1'b1;
      if (w_drop)                                      r_ovf_flag <= 1'b1;
    end
  end

  assign m.m_valid = w_valid;
  assign m.m_data  = r_m_data;
  assign level     = r_count;
  assign sat_flag  = r_sat_flag;
  assign ovf_flag  = r_ovf_flag;

endmodule
